ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, number of memory words.
REQ-003 SHALL have parameter DEPTH_LOG, default $clog2(DEPTH), address width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port prog_start, input, 1, request to enter program mode.
REQ-007 SHALL have port prog_abort, input, 1, return to run mode immediately.
REQ-008 SHALL have port in_valid, input, 1, a program byte is offered.
REQ-009 SHALL have port in_data, input, WIDTH, the program byte.
REQ-010 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have ports cpu_address (DEPTH_LOG), cpu_write (1) and cpu_data (WIDTH), all inputs, run-mode memory access from the CPU.
REQ-012 SHALL have ports mem_address (DEPTH_LOG), mem_write (1) and mem_data (WIDTH), all outputs, to the memory block's address, write and data_in ports.
REQ-013 SHALL have port busy, output, 1, high while in program mode.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when the load completes.
REQ-015 SHALL have port checksum, output, WIDTH, sum of the bytes loaded.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, LOAD, WRITE and DONE.
REQ-017 IDLE: SHALL drive mem_address, mem_write and mem_data combinationally from cpu_address, cpu_write and cpu_data; in_ready=0; busy=0.
REQ-018 IDLE with prog_start=1 SHALL go to LOAD, clear ptr to 0 and clear checksum to 0.
REQ-019 prog_start SHALL be ignored in every state other than IDLE.
REQ-020 LOAD: in_ready=1, mem_write=0, busy=1; cpu_* ignored.
REQ-021 LOAD with in_valid=1 SHALL latch in_data into the byte register and go to WRITE; with in_valid=0 it SHALL stay in LOAD.
REQ-022 WRITE: mem_write=1, mem_address=ptr, mem_data=latched byte (all registered values); in_ready=0; busy=1.
REQ-023 Leaving WRITE with ptr==DEPTH-1 SHALL go to DONE; otherwise it SHALL increment ptr and go to LOAD.
REQ-024 DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE; ptr SHALL wrap to 0.
REQ-025 The block SHALL accept at most one byte per two cycles; a full load SHALL end 2*DEPTH+1 cycles after the first accept when in_valid is held high.
REQ-026 prog_abort=1 at any rising edge SHALL force IDLE at that edge.
REQ-027 An abort SHALL NOT pulse done and SHALL preserve ptr and checksum for inspection.
REQ-028 A WRITE cycle that is in progress when prog_abort is sampled SHALL still complete its write.
REQ-029 prog_abort SHALL take priority over prog_start in the same cycle.
REQ-030 cpu_write SHALL never reach mem_write outside IDLE.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state IDLE, ptr=0, byte register=0 and checksum=0.
REQ-032 Reset SHALL force in_ready=0, busy=0 and done=0.
REQ-033 During reset, the mem_* outputs SHALL pass through cpu_*.
REQ-034 A reset during LOAD or WRITE SHALL abandon the load, with no further writes after release.
REQ-035 After rst_n is released, the block SHALL stay in IDLE until prog_start.

Configuration
REQ-036 With macro LOADER_CHECKSUM_EN defined, each WRITE cycle SHALL add the latched byte into checksum, modulo 2^WIDTH.
REQ-037 Without LOADER_CHECKSUM_EN, checksum SHALL be constant 0, no accumulator logic SHALL be present, and all other behaviour SHALL be identical.

Verification
REQ-038 Run mode: in IDLE drive cpu_address=5, cpu_data=8'hA7, cpu_write=1 -> mem_address=5, mem_data=8'hA7, mem_write=1 in the same cycle.
REQ-039 Full load: prog_start, then 16 bytes 8'h00..8'h0F with in_valid held high -> 16 writes to addresses 0..15, done pulses once, 33 cycles after the first accept; with LOADER_CHECKSUM_EN, checksum=8'h78.
REQ-040 Backpressure: insert 3-cycle in_valid gaps between bytes -> no mem_write during the gaps and the address sequence is unchanged.
REQ-041 Abort: prog_abort after the 4th accepted byte -> exactly 4 writes, busy=0 next cycle, no done, ptr=4 and checksum preserved; cpu_write then passes through.
REQ-042 Reset mid-load: rst_n low during WRITE of address 7 -> outputs at reset values immediately; after release, only CPU writes are observed.

Source files
------------

// File: rtl/ram_loader.sv
// Program loader for a single-port RAM: CPU owns the memory in IDLE, the loader streams bytes into it otherwise.
// Optional running byte checksum is built only when LOADER_CHECKSUM_EN is defined.
module ram_loader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prog_start,
    input  logic                 prog_abort,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    input  logic [DEPTH_LOG-1:0] cpu_address,
    input  logic                 cpu_write,
    input  logic [WIDTH-1:0]     cpu_data,
    output logic [DEPTH_LOG-1:0] mem_address,
    output logic                 mem_write,
    output logic [WIDTH-1:0]     mem_data,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [DEPTH_LOG-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]     byte_q, byte_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state and datapath; abort overrides the state only, so a WRITE in flight still retires.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                if (prog_start && !prog_abort) begin
                    state_d = S_LOAD;
                    ptr_d   = {DEPTH_LOG{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid && !prog_abort) begin
                    byte_d  = in_data;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WRITE: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    ptr_d   = {DEPTH_LOG{1'b0}};
                end else begin
                    state_d = S_LOAD;
                    ptr_d   = ptr_q + DEPTH_LOG'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (prog_abort) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State, pointer, byte register and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= {DEPTH_LOG{1'b0}};
            byte_q     <= {WIDTH{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_q     <= byte_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Memory port mux: CPU passes straight through only while idle (and therefore during reset).
    always_comb begin
        if (state_q == S_IDLE) begin
            mem_address = cpu_address;
            mem_write   = cpu_write;
            mem_data    = cpu_data;
        end else begin
            mem_address = ptr_q;
            mem_write   = (state_q == S_WRITE);
            mem_data    = byte_q;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;

    // Accumulate every retired write; cleared only when a new load starts.
    always_comb begin
        if (state_q == S_IDLE && prog_start && !prog_abort) begin
            sum_d = {WIDTH{1'b0}};
        end else if (state_q == S_WRITE) begin
            sum_d = sum_q + byte_q;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= {WIDTH{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader: run mode, full load, backpressure, abort and mid-load reset.
module tb_ram_loader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int DL    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             prog_start, prog_abort, in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic [DL-1:0]    cpu_address, mem_address;
    logic             cpu_write, mem_write;
    logic [WIDTH-1:0] cpu_data, mem_data, checksum;
    logic             busy, done;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    logic [DL-1:0]    wa[$];
    logic [WIDTH-1:0] wd[$];

    ram_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DL)) dut (
        .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .prog_abort(prog_abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_data(cpu_data),
        .mem_address(mem_address), .mem_write(mem_write), .mem_data(mem_data),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Loader-side write log and done-pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && busy && mem_write) begin
            wa.push_back(mem_address);
            wd.push_back(mem_data);
        end
        if (rst_n && done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        n_done = 0;
    endtask

    task automatic start_load();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
    endtask

    // Offer nbytes bytes base, base+1, ...; gap idle cycles follow each accept.
    task automatic feed(input int nbytes, input logic [7:0] base, input int gap, input bit poke);
        int  k = 0;
        int  g = 0;
        int  budget = 400;
        bit  first = 1'b1;
        while (k < nbytes && budget > 0) begin
            budget--;
            in_valid   = (g == 0);
            in_data    = base + 8'(k);
            prog_start = poke && (k == 8);
            if (in_valid && in_ready) begin
                if (first) begin
                    acc_cyc = cyc;
                    first   = 1'b0;
                end
                k++;
                g = gap;
            end else if (g > 0) begin
                g--;
            end
            tick();
        end
        in_valid   = 1'b0;
        prog_start = 1'b0;
        if (budget == 0) check("feed_timeout", 32'(k), 32'(nbytes));
    endtask

    task automatic wait_done();
        int budget = 20;
        while (n_done == 0 && budget > 0) begin
            budget--;
            tick();
        end
        if (budget == 0) check("done_timeout", 32'(n_done), 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_writes(input string tag, input int n, input logic [7:0] base);
        check({tag, "_count"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check({tag, "_addr"}, 32'(wa[i]), 32'(i));
            check({tag, "_data"}, 32'(wd[i]), 32'(base + 8'(i)));
        end
    endtask

    initial begin
        rst_n = 1'b0; prog_start = 1'b0; prog_abort = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; cpu_address = 4'd3; cpu_write = 1'b1; cpu_data = 8'h55;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_pass_addr", 32'(mem_address), 32'd3);
        check("rst_pass_wr", 32'(mem_write), 32'd1);
        check("rst_pass_data", 32'(mem_data), 32'h55);
        tick(); tick();
        rst_n = 1'b1; cpu_write = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        check("idle_hold_busy", 32'(busy), 32'd0);
        check("idle_hold_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Run mode pass-through
        cpu_address = 4'd5; cpu_data = 8'hA7; cpu_write = 1'b1;
        #1;
        check("run_addr", 32'(mem_address), 32'd5);
        check("run_data", 32'(mem_data), 32'hA7);
        check("run_wr", 32'(mem_write), 32'd1);
        tick();

        // Full load with CPU hammering writes that must be ignored
        cpu_address = 4'd9; cpu_data = 8'hFF; cpu_write = 1'b1;
        clear_log();
        start_load();
        check("load_busy", 32'(busy), 32'd1);
        check("load_ready", 32'(in_ready), 32'd1);
        check("load_nowr", 32'(mem_write), 32'd0);
        feed(16, 8'h00, 0, 1'b1);
        wait_done();
        cpu_write = 1'b0;
        check("full_done_cnt", 32'(n_done), 32'd1);
        check("full_len", 32'(done_cyc - acc_cyc + 1), 32'(2 * DEPTH + 1));
        check_writes("full", 16, 8'h00);
        check("full_busy_after", 32'(busy), 32'd0);
        check("full_ptr_wrap", 32'(dut.ptr_q), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("full_checksum", 32'(checksum), 32'h78);
`else
        check("full_checksum", 32'(checksum), 32'h00);
`endif

        // Backpressure: 3-cycle in_valid gaps
        clear_log();
        start_load();
        feed(16, 8'h40, 3, 1'b0);
        wait_done();
        check("bp_done_cnt", 32'(n_done), 32'd1);
        check_writes("bp", 16, 8'h40);

        // Abort after the 4th accepted byte
        clear_log();
        start_load();
        feed(4, 8'h10, 0, 1'b0);
        tick();
        prog_abort = 1'b1;
        tick();
        prog_abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        check_writes("abort", 4, 8'h10);
        check("abort_ptr", 32'(dut.ptr_q), 32'd4);
`ifdef LOADER_CHECKSUM_EN
        check("abort_checksum", 32'(checksum), 32'h46);
`else
        check("abort_checksum", 32'(checksum), 32'h00);
`endif
        repeat (3) tick();
        check("abort_no_done", 32'(n_done), 32'd0);
        cpu_address = 4'd2; cpu_data = 8'h3C; cpu_write = 1'b1;
        #1;
        check("abort_cpu_wr", 32'(mem_write), 32'd1);
        check("abort_cpu_addr", 32'(mem_address), 32'd2);
        check("abort_cpu_data", 32'(mem_data), 32'h3C);
        cpu_write = 1'b0;

        // Abort wins over start in the same cycle
        tick();
        prog_start = 1'b1; prog_abort = 1'b1;
        tick();
        prog_start = 1'b0; prog_abort = 1'b0;
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_ptr_kept", 32'(dut.ptr_q), 32'd4);

        // Reset during the WRITE of address 7
        clear_log();
        cpu_address = 4'd6; cpu_data = 8'h99; cpu_write = 1'b0;
        start_load();
        feed(8, 8'h20, 0, 1'b0);
        check("pre_rst_wr", 32'(mem_write), 32'd1);
        check("pre_rst_addr", 32'(mem_address), 32'd7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_wr", 32'(mem_write), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd6);
        check("mid_rst_checksum", 32'(checksum), 32'd0);
        check("mid_rst_ptr", 32'(dut.ptr_q), 32'd0);
        tick(); tick();
        rst_n = 1'b1; in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        check("post_rst_writes", 32'(wa.size()), 32'd7);
        check("post_rst_busy", 32'(busy), 32'd0);
        cpu_address = 4'd4; cpu_data = 8'h5A; cpu_write = 1'b1;
        #1;
        check("post_rst_cpu_wr", 32'(mem_write), 32'd1);
        check("post_rst_cpu_data", 32'(mem_data), 32'h5A);
        cpu_write = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
